// File: rtl/vga_pkg.sv
// Shared geometry, colours and fetch FSM encoding for the VGA screen scan path.
package vga_pkg;

    localparam logic [9:0] H_ACTIVE      = 10'd640;
    localparam logic [9:0] V_ACTIVE      = 10'd480;
    localparam logic [9:0] SCR_W         = 10'd512;
    localparam logic [9:0] SCR_H         = 10'd256;
    localparam logic [9:0] SCR_HOFF      = 10'd64;
    localparam logic [9:0] SCR_VOFF      = 10'd112;
    localparam logic [5:0] WORDS_PER_ROW = 6'd32;

    typedef logic [11:0] rgb_t;

    localparam rgb_t FG_RGB     = 12'h000;
    localparam rgb_t BG_RGB     = 12'hFFF;
    localparam rgb_t BORDER_RGB = 12'h00F;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/screen_word_fetcher.sv
// Purpose: one-outstanding req/ack reader of screen words, holding one word ahead (nxt).
// Latency: request rises the cycle after trig; ack data is usable (forwarded) in the ack cycle.
// Backpressure: a trigger during an outstanding request is held and issued after DONE.
module screen_word_fetcher
    import vga_pkg::*;
(
    input  logic        clk50,
    input  logic        rst_n,
    input  logic        trig,
    input  logic [12:0] trig_addr,
    input  logic        take,
    input  logic        flush,
    output logic        mem_req,
    output logic [12:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        word_vld,
    output logic [15:0] word_dat
);

    fetch_state_t state;
    logic [15:0]  nxt;
    logic         nxt_valid;
    logic         discard;
    logic         pend;
    logic [12:0]  pend_addr;
    logic         ack_ok;
    logic         fwd;
    logic         outstanding;
    logic         starve;

    assign ack_ok      = (state == FETCH_REQ) && mem_ack;
    assign fwd         = ack_ok && !discard;
    assign word_vld    = nxt_valid || fwd;
    assign word_dat    = nxt_valid ? nxt : mem_rdata;
    assign starve      = take && !word_vld;
    // An ack landing this cycle retires the request, so it no longer needs discarding.
    assign outstanding = (state == FETCH_REQ) && !mem_ack;

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            nxt       <= '0;
            nxt_valid <= 1'b0;
            discard   <= 1'b0;
            pend      <= 1'b0;
            pend_addr <= '0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (trig || pend) begin
                        state    <= FETCH_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= trig ? trig_addr : pend_addr;
                    end
                end
                FETCH_REQ: begin
                    if (mem_ack) begin
                        state   <= FETCH_DONE;
                        mem_req <= 1'b0;
                    end
                end
                FETCH_DONE: state <= FETCH_IDLE;
                default:    state <= FETCH_IDLE;
            endcase

            if (state == FETCH_IDLE) begin
                pend <= 1'b0;
            end else if (trig) begin
                pend      <= 1'b1;
                pend_addr <= trig_addr;
            end

            if (fwd) nxt <= mem_rdata;
            if (flush || take) nxt_valid <= 1'b0;
            else if (fwd)      nxt_valid <= 1'b1;

            if ((flush || starve) && outstanding) discard <= 1'b1;
            else if (ack_ok)                      discard <= 1'b0;
        end
    end

endmodule

// File: rtl/vga_screen_scan.sv
// Purpose: centre the 512x256 Hack screen in 640x480 and colour each pixel; VGA_UNDERRUN_CNT_EN builds the underrun counter.
// Latency: rgb registers on the pix_ce edge that samples the coordinates (1 pixel).
// Backpressure: none upstream; a word missing at its boundary shows as background and is an underrun.
module vga_screen_scan
    import vga_pkg::*;
(
    input  logic        clk50,
    input  logic        rst_n,
    input  logic        pix_ce,
    input  logic [9:0]  counter_x,
    input  logic [9:0]  counter_y,
    input  logic        in_display,
    output logic        mem_req,
    output logic [12:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [11:0] rgb,
    output logic [15:0] underrun_cnt
);

    logic        in_win_x;
    logic        in_win_y;
    logic        in_win;
    logic        visible;
    logic        row_start;
    logic        boundary;
    logic        last_col;
    logic        row_active;
    logic [4:0]  col;
    logic [7:0]  row;
    logic [7:0]  row_now;
    logic [15:0] cur;
    logic [15:0] fetched;
    logic [15:0] act_word;
    logic        pix_bit;
    logic        trig;
    logic [12:0] trig_addr;
    logic        word_vld;
    logic [15:0] word_dat;

    assign in_win_x = (counter_x >= SCR_HOFF) && (counter_x < SCR_HOFF + SCR_W);
    assign in_win_y = (counter_y >= SCR_VOFF) && (counter_y < SCR_VOFF + SCR_H);
    assign in_win   = in_win_x && in_win_y;
    assign visible  = in_display && (counter_x < H_ACTIVE) && (counter_y < V_ACTIVE);

    // Only the low bits of wy/wx matter: the row fits 8 bits and SCR_HOFF is 16-aligned.
    assign row_now   = counter_y[7:0] - SCR_VOFF[7:0];
    assign row_start = pix_ce && (counter_x == 10'd0) && in_win_y;
    assign boundary  = pix_ce && row_active && in_win && (counter_x[3:0] == 4'd0);
    assign last_col  = ({1'b0, col} == WORDS_PER_ROW - 6'd1);

    assign trig      = row_start || (boundary && !last_col);
    assign trig_addr = row_start ? {row_now, 5'd0} : {row, col + 5'd1};

    assign fetched  = word_vld ? word_dat : 16'h0000;
    assign act_word = boundary ? fetched : cur;
    assign pix_bit  = act_word[counter_x[3:0]];

    screen_word_fetcher u_fetcher (
        .clk50     (clk50),
        .rst_n     (rst_n),
        .trig      (trig),
        .trig_addr (trig_addr),
        .take      (boundary),
        .flush     (row_start),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .word_vld  (word_vld),
        .word_dat  (word_dat)
    );

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            rgb        <= '0;
            cur        <= '0;
            col        <= '0;
            row        <= '0;
            row_active <= 1'b0;
        end else if (pix_ce) begin
            if (row_start) begin
                row        <= row_now;
                col        <= '0;
                row_active <= 1'b1;
            end else if (boundary) begin
                cur <= fetched;
                if (!last_col) col <= col + 5'd1;
            end

            if (!visible)    rgb <= '0;
            else if (in_win) rgb <= pix_bit ? FG_RGB : BG_RGB;
            else             rgb <= BORDER_RGB;
        end
    end

`ifdef VGA_UNDERRUN_CNT_EN
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n)
            underrun_cnt <= '0;
        else if (boundary && !word_vld && (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_screen_scan.sv
// Directed bench for vga_screen_scan: drives scan rows, answers screen reads with a latency-programmable responder.
module tb_vga_screen_scan;

    logic        clk50 = 1'b0;
    logic        rst_n;
    logic        pix_ce;
    logic [9:0]  counter_x;
    logic [9:0]  counter_y;
    logic        in_display;
    logic        mem_req;
    logic [12:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic [11:0] rgb;
    logic [15:0] underrun_cnt;

    int checks = 0;
    int errors = 0;
    int base   = 0;

    logic [11:0] line_rgb [0:799];
    logic [12:0] req_log  [0:511];
    int          req_n    = 0;
    int          wcnt     = 0;
    bit          req_seen = 1'b0;
    logic [12:0] slow_addr = 13'h1FFF;
    int          slow_lat  = 0;

`ifdef VGA_UNDERRUN_CNT_EN
    localparam int UR_EXP = 1;
`else
    localparam int UR_EXP = 0;
`endif

    always #5 clk50 = ~clk50;

    vga_screen_scan dut (
        .clk50        (clk50),
        .rst_n        (rst_n),
        .pix_ce       (pix_ce),
        .counter_x    (counter_x),
        .counter_y    (counter_y),
        .in_display   (in_display),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .rgb          (rgb),
        .underrun_cnt (underrun_cnt)
    );

    function automatic logic [15:0] mem_word(input logic [12:0] a);
        if (a == 13'd0) return 16'h0001;
        return {3'b101, a};
    endfunction

    // Screen RAM responder: logs each new request, acks after slow_lat cycles for slow_addr, else at once.
    always @(negedge clk50) begin
        mem_ack = 1'b0;
        if (mem_req) begin
            if (!req_seen) begin
                req_seen = 1'b1;
                if (req_n < 512) req_log[req_n] = mem_addr;
                req_n++;
                wcnt = 0;
            end
            if (wcnt >= ((mem_addr == slow_addr) ? slow_lat : 0)) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
            end else begin
                wcnt++;
            end
        end else begin
            req_seen = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scan_pixels(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            @(negedge clk50);
            counter_x  = 10'(x);
            counter_y  = 10'(y);
            in_display = (x < 640) && (y < 480);
            pix_ce     = 1'b1;
            @(negedge clk50);
            pix_ce      = 1'b0;
            line_rgb[x] = rgb;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        pix_ce     = 1'b0;
        counter_x  = '0;
        counter_y  = '0;
        in_display = 1'b0;
        repeat (3) @(negedge clk50);
        check("reset_rgb", 32'(rgb), 32'h000);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_underrun", 32'(underrun_cnt), 32'd0);
        rst_n = 1'b1;

        // Row above the window: border colour, no fetches.
        base = req_n;
        scan_pixels(111, 0, 799);
        check("y111_reqs", 32'(req_n - base), 32'd0);
        check("border_300_111", 32'(line_rgb[300]), 32'h00F);

        // Screen row 0: word 0 = 16'h0001, word 1 = 16'hA001.
        base = req_n;
        scan_pixels(112, 0, 799);
        check("y112_reqs", 32'(req_n - base), 32'd32);
        check("px64_y112", 32'(line_rgb[64]), 32'h000);
        for (int x = 65; x <= 79; x++)
            check($sformatf("bg_x%0d_y112", x), 32'(line_rgb[x]), 32'hFFF);
        check("px80_y112", 32'(line_rgb[80]), 32'h000);

        // Screen row 1: word 3 (addr 35, 16'hA023) acks on its own boundary cycle.
        slow_addr = 13'd35;
        slow_lat  = 31;
        base = req_n;
        scan_pixels(113, 0, 799);
        check("y113_reqs", 32'(req_n - base), 32'd32);
        for (int i = 0; i < 32; i++)
            check($sformatf("y113_addr%0d", i), 32'(req_log[base + i]), 32'(32 + i));
        check("fwd_px112", 32'(line_rgb[112]), 32'h000);
        check("fwd_px113", 32'(line_rgb[113]), 32'h000);
        check("fwd_px114", 32'(line_rgb[114]), 32'hFFF);
        check("fwd_px117", 32'(line_rgb[117]), 32'h000);
        check("fwd_underrun", 32'(underrun_cnt), 32'd0);

        // Screen row 88: word 5 (addr 2821) is 40 cycles late; word 6 = 16'hAB06.
        slow_addr = 13'd2821;
        slow_lat  = 40;
        base = req_n;
        scan_pixels(200, 0, 799);
        check("y200_reqs", 32'(req_n - base), 32'd32);
        check("border_63_200", 32'(line_rgb[63]), 32'h00F);
        check("border_580_200", 32'(line_rgb[580]), 32'h00F);
        check("blank_700_200", 32'(line_rgb[700]), 32'h000);
        for (int x = 144; x <= 159; x++)
            check($sformatf("ur_x%0d", x), 32'(line_rgb[x]), 32'hFFF);
        check("w6_px160", 32'(line_rgb[160]), 32'hFFF);
        check("w6_px161", 32'(line_rgb[161]), 32'h000);
        check("w6_px168", 32'(line_rgb[168]), 32'h000);
        check("w6_px170", 32'(line_rgb[170]), 32'hFFF);
        check("ur_count", 32'(underrun_cnt), 32'(UR_EXP));

        // Screen row 89: word 10 never answers; reset mid-request, release at x=300.
        slow_addr = 13'd2858;
        slow_lat  = 1000;
        scan_pixels(201, 0, 250);
        check("midrow_req_pending", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mem_req", 32'(mem_req), 32'd0);
        check("async_rst_rgb", 32'(rgb), 32'h000);
        check("async_rst_underrun", 32'(underrun_cnt), 32'd0);
        scan_pixels(201, 251, 299);
        rst_n = 1'b1;
        base = req_n;
        scan_pixels(201, 300, 799);
        check("post_rst_reqs", 32'(req_n - base), 32'd0);

        // Screen row 90: normal fetch from col 0 (addr 2880, word 16'hAB40).
        slow_lat = 0;
        base = req_n;
        scan_pixels(202, 0, 799);
        check("y202_reqs", 32'(req_n - base), 32'd32);
        check("y202_first_addr", 32'(req_log[base]), 32'd2880);
        check("y202_last_addr", 32'(req_log[base + 31]), 32'd2911);
        check("y202_px64", 32'(line_rgb[64]), 32'hFFF);
        check("y202_px70", 32'(line_rgb[70]), 32'h000);
        check("y202_underrun", 32'(underrun_cnt), 32'd0);

        // Row below the window.
        base = req_n;
        scan_pixels(368, 0, 799);
        check("y368_reqs", 32'(req_n - base), 32'd0);
        check("border_300_368", 32'(line_rgb[300]), 32'h00F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_screen_scan.md
# vga_screen_scan

Downstream pixel stage of the VGA path: consumes the 640x480 scan position from the sync generator and produces 12-bit RGB for each pixel. It centres the 512x256 monochrome Hack screen in the active area and fetches 16-bit screen words from screen RAM over a req/ack port. Fetches run one word ahead, and a late word is reported as an underrun.

## Interface
- FG_RGB, 12'h000, colour for screen bit = 1 (Hack black)
- BG_RGB, 12'hFFF, colour for screen bit = 0
- BORDER_RGB, 12'h00F, colour inside 640x480 but outside the 512x256 window
- clk50  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- pix_ce  in  1  one-cycle pixel strobe, every second clk50 cycle (25 MHz)
- counter_x  in  10  horizontal scan position, 0..800
- counter_y  in  10  vertical scan position, 0..525
- in_display  in  1  registered active-area flag from the sync generator
- mem_req  out  1  read request
- mem_addr  out  13  screen word address {row[7:0], col[4:0]}
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid same cycle
- mem_rdata  in  16  screen word; bit 0 = leftmost pixel
- rgb  out  12  pixel colour
- underrun_cnt  out  16  saturating underrun count (see Configuration)

## Operation
- Window: x in [64,575], y in [112,367]. wx = x-64, wy = y-112.
- Registers: cur (shift word), nxt + nxt_valid, col[4:0], row[7:0], discard flag.
- Fetch FSM has 3 states: IDLE, REQ, DONE.
  - IDLE -> REQ when a fetch is triggered; mem_req=1 and mem_addr stable until ack.
  - REQ -> DONE on mem_ack. On that ack: nxt<=mem_rdata and nxt_valid<=1, unless discard is set. If discard is set, clear discard and drop the data.
  - DONE -> IDLE next cycle. Exactly one request may be outstanding.
- Row start, on pix_ce with counter_x==0 and y in window:
  - row<=wy, col<=0, nxt_valid<=0.
  - Set discard if a request is outstanding.
  - Trigger a fetch of column 0.
- Word boundary, on pix_ce with pixel in window and wx[3:0]==0:
  - If nxt_valid: cur<=nxt and nxt_valid<=0.
  - Else it is an underrun: cur<=0, underrun event, and set discard if a request is outstanding.
  - In both cases, if col<31, col<=col+1 and trigger a fetch of the new col.
  - A trigger that lands while a request is outstanding is held and issued in the cycle after DONE.
- Pixel, on pix_ce:
  - !in_display: rgb<=0.
  - In display but outside the window: rgb<=BORDER_RGB.
  - Inside the window: rgb<= bit wx[3:0] of the active word ? FG_RGB : BG_RGB. The active word is the word just loaded on a boundary pixel, cur otherwise.
- Width rules: all subtractions are 10-bit unsigned, evaluated only inside the window. Address = row*32+col, never above 8191.

## Timing
- Reset (async): rgb=0, mem_req=0, mem_addr=0, underrun_cnt=0, nxt_valid=0, discard=0, FSM=IDLE.
- rgb updates on the clk50 edge where pix_ce=1 and reflects the coordinates sampled on that edge. This is 1 pixel of latency, aligned with the registered syncs.
- First word of a row: 64 pixels (128 clk50) of slack.
- Each later word: 16 pixels (32 clk50) of slack. Memory latency above ~30 cycles underruns.
- mem_req rises the cycle after a trigger and falls the cycle after mem_ack.
- The last word of a row (col 31) triggers no further fetch.
- Rows outside the window issue no requests.
- Simultaneous ack and word boundary in one cycle: the ack data is used (forwarded) and is not counted as an underrun.

## Configuration
- VGA_UNDERRUN_CNT_EN defined: underrun_cnt increments on each underrun event, saturates at 16'hFFFF, and clears only on reset.
- Not defined: underrun_cnt is tied to 0 and no counter logic is built. Pixel behaviour is identical either way.

## Structure
- Package vga_pkg holds: H_ACTIVE=640, V_ACTIVE=480, SCR_W=512, SCR_H=256, SCR_HOFF=64, SCR_VOFF=112, WORDS_PER_ROW=32, the fetch FSM state enum, and the rgb type (12-bit).
- One sub-module, screen_word_fetcher. It owns the req/ack FSM, the pending-trigger latch and the discard flag, and hands nxt/nxt_valid to the scan logic.

## Test plan
- Reset: assert rst_n=0 mid-request -> mem_req drops asynchronously, rgb=0, underrun_cnt=0.
- Zero-wait memory returns 16'h0001 for word 0 of row 0 -> (64,112) is FG_RGB 12'h000 and (65..79,112) are BG_RGB 12'hFFF, one pixel after the coordinates.
- Address order: scan y=113 -> mem_addr sequence 32,33,...,63 with exactly 32 requests, and none for y=111 or y=368.
- Border: pixel (63,200) and (300,111) -> 12'h00F; x=700 (blanking) -> 12'h000.
- Underrun: delay ack for word 5 of a row by 40 cycles -> pixels wx 80..95 are BG_RGB, underrun_cnt=1 (with the macro), the late data is discarded, and word 6 displays correctly.
- Mid-row reset release: deassert rst_n at x=300 -> no requests until the next row start, then normal fetch from col 0.
